// File: rtl/mon_frame_transceiver.sv
// -----------------------------------------------------------------------------
// mon_frame_transceiver
// Bidirectional serial frame engine for the monitor link.
//   Rx: start bit (1), FRAME_W data bits MSB first, optional parity bit. The
//       frame is deserialised into a DEPTH-entry first-word-fall-through FIFO
//       that is read through a valid/ready interface.
//   Tx: a frame taken on a valid/ready handshake is sent with the same format
//       on from_mon. from_mon is registered.
// Optional feature macro: MON_PARITY_EN (even parity bit on both paths).
//
// Ports:
//   mon_clk      in   sole clock, rising edge
//   mon_rst_n    in   asynchronous active-low reset
//   to_mon       in   serial rx line, idle low
//   from_mon     out  serial tx line, registered, idle low
//   rx_data      out  FIFO head frame
//   rx_valid     out  FIFO not empty
//   rx_ready     in   pop head when rx_valid && rx_ready
//   rx_count     out  FIFO occupancy
//   rx_overflow  out  one-cycle pulse when a completed frame is dropped
//   parity_err   out  one-cycle pulse on rx parity mismatch (0 without parity)
//   tx_data      in   frame to send
//   tx_valid     in   tx request
//   tx_ready     out  high exactly when the tx FSM is idle
//
// Rx FSM   state   | meaning
//          RX_IDLE | waiting for a start bit
//          RX_DATA | sampling data bits, MSB first
//          RX_PAR  | sampling the parity bit (MON_PARITY_EN only)
// Tx FSM   state    | meaning
//          TX_IDLE  | line low, ready for a handshake
//          TX_START | driving the start bit
//          TX_DATA  | driving data bits, MSB first
//          TX_PAR   | driving the parity bit (MON_PARITY_EN only)
// -----------------------------------------------------------------------------
module mon_frame_transceiver #(
    parameter int FRAME_W = 40,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               mon_clk,
    input  logic               mon_rst_n,
    input  logic               to_mon,
    output logic               from_mon,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [CNT_W-1:0]   rx_count,
    output logic               rx_overflow,
    output logic               parity_err,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready
);
    localparam int BIT_W = $clog2(FRAME_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR} tx_state_e;

    // ---------------------------------------------------------------- rx FSM
    rx_state_e          rx_state_q, rx_state_d;
    logic [BIT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
    logic               rx_push;

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (to_mon) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = '0;
                end
            end
            RX_DATA: begin
                rx_sh_d  = {rx_sh_q[FRAME_W-2:0], to_mon};
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST_BIT) begin
`ifdef MON_PARITY_EN
                    rx_state_d = RX_PAR;
`else
                    rx_state_d = RX_IDLE;
`endif
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef MON_PARITY_EN
    logic rx_par_fail;
    logic par_err_q;

    always_comb begin
        rx_push     = 1'b0;
        rx_par_fail = 1'b0;
        if (rx_state_q == RX_PAR) begin
            // even parity: data XOR parity bit must be zero
            if ((^rx_sh_q) == to_mon) rx_push = 1'b1;
            else rx_par_fail = 1'b1;
        end
    end

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) par_err_q <= 1'b0;
        else par_err_q <= rx_par_fail;
    end

    assign parity_err = par_err_q;
`else
    always_comb begin
        rx_push = 1'b0;
        if (rx_state_q == RX_DATA && rx_cnt_q == LAST_BIT) rx_push = 1'b1;
    end

    assign parity_err = 1'b0;
`endif

    // ---------------------------------------------------------------- rx FIFO
    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;
    logic               pop, push_ok;

    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid && rx_ready;
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    assign push_ok  = rx_push && ((count_q != FULL_CNT) || pop);

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= rx_sh_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop) count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            overflow_q <= rx_push && !push_ok;
        end
    end

    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_count    = count_q;
    assign rx_overflow = overflow_q;

    // ---------------------------------------------------------------- tx FSM
    tx_state_e          tx_state_q, tx_state_d;
    logic [BIT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
    logic               from_mon_q, from_mon_d;

`ifdef MON_PARITY_EN
    logic tx_par_q;

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) tx_par_q <= 1'b0;
        else if (tx_state_q == TX_IDLE && tx_valid) tx_par_q <= ^tx_data;
    end
`endif

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_sh_q    <= '0;
            from_mon_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            from_mon_q <= from_mon_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = tx_data;
                    tx_cnt_d   = '0;
                end
            end
            TX_START: tx_state_d = TX_DATA;
            TX_DATA: begin
                tx_sh_d  = tx_sh_q << 1;
                tx_cnt_d = tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST_BIT) begin
`ifdef MON_PARITY_EN
                    tx_state_d = TX_PAR;
`else
                    tx_state_d = TX_IDLE;
`endif
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // from_mon is registered from the next state, so the line value always
    // matches the state the FSM is in during that cycle
    always_comb begin
        tx_ready = (tx_state_q == TX_IDLE);
        case (tx_state_d)
            TX_START: from_mon_d = 1'b1;
            TX_DATA:  from_mon_d = tx_sh_d[FRAME_W-1];
`ifdef MON_PARITY_EN
            TX_PAR:   from_mon_d = tx_par_q;
`endif
            default:  from_mon_d = 1'b0;
        endcase
    end

    assign from_mon = from_mon_q;

endmodule
